match_referee: RTL
==================

// Module: match_referee
// PURPOSE
//  Referee for the two-player fighter: sequences each match into rounds and turns, collects both players'
//  actions, issues them to firstPlayer/secondPlayer together as one step pulse, watches both healths, then
//  declares round and match winners. Sits between the input decoders and the two player modules.
// PARAMETERS
//  TURN_TIMEOUT   15  cycles in COLLECT before a missing action defaults to await (3'b010)
//  MAX_TURNS      31  turns per round before a time-out decision
//  ROUNDS_TO_WIN  2   round wins that end the match (1..3)
//  COUNTDOWN      3   idle cycles between round_rst and the first COLLECT
// PORTS
//  clk          in   1  system clock, all flops on posedge
//  rst          in   1  asynchronous, active-high reset
//  start        in   1  pulse: begin a new match (ignored unless IDLE or MATCH_END)
//  act1_valid   in   1  player-1 action present this cycle
//  act1         in   3  player-1 action code (kick..right2)
//  act2_valid   in   1  player-2 action present this cycle
//  act2         in   3  player-2 action code
//  health1      in   2  player-1 health, from the player module
//  health2      in   2  player-2 health
//  action1_out  out  3  latched action driven to player 1
//  action2_out  out  3  latched action driven to player 2
//  step         out  1  one-cycle enable: players evaluate action*_out only when step=1
//  round_rst    out  1  one-cycle pulse: players restore health=3 and start positions
//  round_num    out  2  current round, 1-based, saturates at 3
//  wins1/wins2  out  2  rounds won by each player
//  turn_cnt     out  5  turns completed in the current round
//  winner       out  2  00 none, 01 P1, 10 P2, 11 draw (valid when match_over)
//  match_over   out  1  high in MATCH_END
// BEHAVIOUR
//  Reset: state=IDLE; action*_out=3'b010 (await); step=0; round_rst=0; round_num=0; wins*=0; turn_cnt=0;
//   winner=00; match_over=0; collect flags and timers cleared. Mid-match rst aborts immediately to IDLE.
//  States: IDLE, ROUND_INIT, COUNTDOWN, COLLECT, ISSUE, SETTLE, ROUND_END, MATCH_END.
//  IDLE/MATCH_END -start-> ROUND_INIT: wins*=0, round_num=1, winner=00, match_over=0.
//  ROUND_INIT (1 cycle): round_rst=1, turn_cnt=0 -> COUNTDOWN (COUNTDOWN cycles) -> COLLECT.
//  COLLECT: first valid action per player latched, later ones that turn ignored; leave when both latched or
//   timer hits TURN_TIMEOUT (unlatched player gets await). Simultaneous valid and timeout: valid wins.
//  ISSUE (1 cycle): step=1, action*_out hold latched values; turn_cnt+=1 -> SETTLE.
//  SETTLE (1 cycle): sample health1/health2 (players update on the step edge, so read here, not in ISSUE).
//   KO = health==0. Both KO -> draw round. One KO -> other wins. Neither and turn_cnt==MAX_TURNS ->
//   higher health wins, equal = draw. Otherwise clear latches -> COLLECT.
//  ROUND_END (1 cycle): winner's wins+=1 (draw: none); if any wins==ROUNDS_TO_WIN -> MATCH_END, winner set;
//   else if round_num==3 -> MATCH_END, winner = more wins, equal -> 11; else round_num+=1 -> ROUND_INIT.
//  step and round_rst never high together; action*_out = await outside ISSUE-hold and after reset.
//  wins* never exceed ROUNDS_TO_WIN; round_num saturates at 3; turn_cnt never wraps (MAX_TURNS<=31).
//  start during COLLECT..ROUND_END ignored. Health value 3 after a 1->wrap is treated as alive (not KO).
// STRUCTURE
//  game_pkg: action codes (kick..right2), referee state encoding, winner codes, position one-hot codes.
//  Sub-module turn_timer: loadable down-counter with terminal flag, used for COUNTDOWN and TURN_TIMEOUT.
//  Top holds FSM, action latches, round/win/turn counters.
// TESTING
//  rst mid-COLLECT with act1 latched -> next cycle IDLE, action*_out=010, wins*=0, step=0.
//  start; act1=kick, act2=punch same cycle -> one ISSUE cycle step=1, action1_out=000, action2_out=001.
//  only act1=jump, act2 silent 15 cycles -> ISSUE with action2_out=010, turn_cnt=1.
//  health2 driven 0 in SETTLE, health1=2 -> wins1=1, round_rst pulse, round_num=2.
//  P1 wins rounds 1 and 2 -> match_over=1, winner=01, round_num=2; start restarts at round_num=1.
//  31 turns, health1=health2=2 -> draw round, wins unchanged; three draws -> winner=11.

Source files
------------

// File: rtl/match_referee_pkg.sv
// Purpose : shared encodings for the fighter referee: action codes, referee FSM
//           states, winner codes, position one-hot codes and the per-turn
//           round-decision helper.
// Contents: ACT_* (3-bit action codes), ref_state_e, WIN_* (2-bit winner codes),
//           POS_* (4-bit one-hot positions), settle_result().
package match_referee_pkg;

    // Player action codes as issued to the player modules.
    localparam logic [2:0] ACT_KICK   = 3'b000;
    localparam logic [2:0] ACT_PUNCH  = 3'b001;
    localparam logic [2:0] ACT_AWAIT  = 3'b010;
    localparam logic [2:0] ACT_JUMP   = 3'b011;
    localparam logic [2:0] ACT_LEFT1  = 3'b100;
    localparam logic [2:0] ACT_RIGHT1 = 3'b101;
    localparam logic [2:0] ACT_LEFT2  = 3'b110;
    localparam logic [2:0] ACT_RIGHT2 = 3'b111;

    // Winner / round-result codes.
    localparam logic [1:0] WIN_NONE = 2'b00;
    localparam logic [1:0] WIN_P1   = 2'b01;
    localparam logic [1:0] WIN_P2   = 2'b10;
    localparam logic [1:0] WIN_DRAW = 2'b11;

    // Arena positions, one-hot, as used by the player modules.
    localparam logic [3:0] POS_0 = 4'b0001;
    localparam logic [3:0] POS_1 = 4'b0010;
    localparam logic [3:0] POS_2 = 4'b0100;
    localparam logic [3:0] POS_3 = 4'b1000;

    localparam int unsigned TIMER_W = 5;

    typedef enum logic [2:0] {
        StIdle,
        StRoundInit,
        StCountdown,
        StCollect,
        StIssue,
        StSettle,
        StRoundEnd,
        StMatchEnd
    } ref_state_e;

    // Result of one settled turn. WIN_NONE means the round continues.
    // Only health 0 is a KO; 3 (including a wrapped value) counts as alive.
    function automatic logic [1:0] settle_result(input logic [1:0] h1,
                                                 input logic [1:0] h2,
                                                 input logic       at_limit);
        logic [1:0] res;
        res = WIN_NONE;
        if (h1 == 2'd0 && h2 == 2'd0) begin
            res = WIN_DRAW;
        end else if (h2 == 2'd0) begin
            res = WIN_P1;
        end else if (h1 == 2'd0) begin
            res = WIN_P2;
        end else if (at_limit) begin
            if (h1 > h2) begin
                res = WIN_P1;
            end else if (h2 > h1) begin
                res = WIN_P2;
            end else begin
                res = WIN_DRAW;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/match_referee_turn_timer.sv
// Purpose : loadable down-counter with terminal flag; the referee uses it for
//           the pre-round countdown and for the per-turn collect timeout.
// Ports   : i_clk, i_rst (async, active-high), i_load/i_load_val (load has
//           priority), i_en (decrement, stops at zero), o_done (count == 0).
module match_referee_turn_timer #(
    parameter int unsigned WIDTH = 5
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    input  logic             i_en,
    output logic             o_done
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_en && (r_count != '0)) begin
            r_count <= r_count - WIDTH'(1);
        end
    end

    always_comb begin
        o_done = (r_count == '0);
    end

endmodule

// File: rtl/match_referee.sv
// Purpose : referee for the two-player fighter. Sequences a match into rounds
//           and turns, collects both players' actions, issues them together on
//           a one-cycle step, reads back both healths and decides round and
//           match winners.
// Ports   : i_clk, i_rst (async, active-high), i_start (new match),
//           i_act{1,2}_valid / i_act{1,2} (action inputs), i_health{1,2},
//           o_action{1,2}_out, o_step, o_round_rst, o_round_num, o_wins{1,2},
//           o_turn_cnt, o_winner, o_match_over.
module match_referee
    import match_referee_pkg::*;
#(
    parameter int unsigned TURN_TIMEOUT  = 15,
    parameter int unsigned MAX_TURNS     = 31,
    parameter int unsigned ROUNDS_TO_WIN = 2,
    parameter int unsigned COUNTDOWN     = 3
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_start,
    input  logic       i_act1_valid,
    input  logic [2:0] i_act1,
    input  logic       i_act2_valid,
    input  logic [2:0] i_act2,
    input  logic [1:0] i_health1,
    input  logic [1:0] i_health2,
    output logic [2:0] o_action1_out,
    output logic [2:0] o_action2_out,
    output logic       o_step,
    output logic       o_round_rst,
    output logic [1:0] o_round_num,
    output logic [1:0] o_wins1,
    output logic [1:0] o_wins2,
    output logic [4:0] o_turn_cnt,
    output logic [1:0] o_winner,
    output logic       o_match_over
);

    // Timer counts down to zero inclusive, so load N-1 for an N-cycle window.
    localparam logic [TIMER_W-1:0] TIMEOUT_LOAD = TIMER_W'(TURN_TIMEOUT - 1);
    localparam logic [TIMER_W-1:0] CD_LOAD      = TIMER_W'(COUNTDOWN - 1);
    localparam logic [4:0]         MAX_T        = 5'(MAX_TURNS);
    localparam logic [1:0]         RTW          = 2'(ROUNDS_TO_WIN);

    ref_state_e r_state, w_state_nxt;

    logic       r_got1, r_got2;
    logic [2:0] r_lat1, r_lat2;
    logic [1:0] r_round_num, r_wins1, r_wins2, r_winner, r_round_res;
    logic [4:0] r_turn_cnt;

    logic                 w_take1, w_take2;
    logic                 w_timer_load, w_timer_en, w_timer_done;
    logic [TIMER_W-1:0]   w_timer_val;
    logic [1:0]           w_settle_res;
    logic [1:0]           w_wins1_inc, w_wins2_inc, w_final_winner;

    match_referee_turn_timer #(
        .WIDTH (TIMER_W)
    ) u_timer (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_load     (w_timer_load),
        .i_load_val (w_timer_val),
        .i_en       (w_timer_en),
        .o_done     (w_timer_done)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_timer_load   = 1'b0;
        w_timer_val    = '0;
        w_timer_en     = 1'b0;
        w_take1        = 1'b0;
        w_take2        = 1'b0;
        w_settle_res   = settle_result(i_health1, i_health2, r_turn_cnt == MAX_T);
        w_wins1_inc    = r_wins1 + {1'b0, (r_round_res == WIN_P1)};
        w_wins2_inc    = r_wins2 + {1'b0, (r_round_res == WIN_P2)};
        w_final_winner = WIN_DRAW;
        if (w_wins1_inc == RTW) begin
            w_final_winner = WIN_P1;
        end else if (w_wins2_inc == RTW) begin
            w_final_winner = WIN_P2;
        end else if (w_wins1_inc > w_wins2_inc) begin
            w_final_winner = WIN_P1;
        end else if (w_wins2_inc > w_wins1_inc) begin
            w_final_winner = WIN_P2;
        end

        case (r_state)
            StIdle, StMatchEnd: begin
                if (i_start) begin
                    w_state_nxt = StRoundInit;
                end
            end
            StRoundInit: begin
                w_timer_load = 1'b1;
                w_timer_val  = CD_LOAD;
                w_state_nxt  = StCountdown;
            end
            StCountdown: begin
                if (w_timer_done) begin
                    w_timer_load = 1'b1;
                    w_timer_val  = TIMEOUT_LOAD;
                    w_state_nxt  = StCollect;
                end else begin
                    w_timer_en = 1'b1;
                end
            end
            StCollect: begin
                // A valid arriving on the timeout cycle is still latched.
                w_take1 = i_act1_valid && !r_got1;
                w_take2 = i_act2_valid && !r_got2;
                if (((r_got1 || w_take1) && (r_got2 || w_take2)) || w_timer_done) begin
                    w_state_nxt = StIssue;
                end else begin
                    w_timer_en = 1'b1;
                end
            end
            StIssue: begin
                w_state_nxt = StSettle;
            end
            StSettle: begin
                if (w_settle_res != WIN_NONE) begin
                    w_state_nxt = StRoundEnd;
                end else begin
                    w_timer_load = 1'b1;
                    w_timer_val  = TIMEOUT_LOAD;
                    w_state_nxt  = StCollect;
                end
            end
            StRoundEnd: begin
                if ((w_wins1_inc == RTW) || (w_wins2_inc == RTW) || (r_round_num == 2'd3)) begin
                    w_state_nxt = StMatchEnd;
                end else begin
                    w_state_nxt = StRoundInit;
                end
            end
            default: begin
                w_state_nxt = StIdle;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_lat1      <= ACT_AWAIT;
            r_lat2      <= ACT_AWAIT;
            r_got1      <= 1'b0;
            r_got2      <= 1'b0;
            r_round_num <= 2'd0;
            r_wins1     <= 2'd0;
            r_wins2     <= 2'd0;
            r_turn_cnt  <= 5'd0;
            r_winner    <= WIN_NONE;
            r_round_res <= WIN_NONE;
        end else begin
            case (r_state)
                StIdle, StMatchEnd: begin
                    if (i_start) begin
                        r_wins1     <= 2'd0;
                        r_wins2     <= 2'd0;
                        r_round_num <= 2'd1;
                        r_winner    <= WIN_NONE;
                    end
                end
                StRoundInit: begin
                    r_turn_cnt <= 5'd0;
                    r_lat1     <= ACT_AWAIT;
                    r_lat2     <= ACT_AWAIT;
                    r_got1     <= 1'b0;
                    r_got2     <= 1'b0;
                end
                StCollect: begin
                    if (w_take1) begin
                        r_lat1 <= i_act1;
                        r_got1 <= 1'b1;
                    end
                    if (w_take2) begin
                        r_lat2 <= i_act2;
                        r_got2 <= 1'b1;
                    end
                    // Count on entry to ISSUE so the issued turn is visible during step.
                    if (w_state_nxt == StIssue) begin
                        r_turn_cnt <= r_turn_cnt + 5'd1;
                    end
                end
                StSettle: begin
                    r_round_res <= w_settle_res;
                    if (w_state_nxt == StCollect) begin
                        r_lat1 <= ACT_AWAIT;
                        r_lat2 <= ACT_AWAIT;
                        r_got1 <= 1'b0;
                        r_got2 <= 1'b0;
                    end
                end
                StRoundEnd: begin
                    r_wins1 <= w_wins1_inc;
                    r_wins2 <= w_wins2_inc;
                    if (w_state_nxt == StRoundInit) begin
                        r_round_num <= r_round_num + 2'd1;
                    end else begin
                        r_winner <= w_final_winner;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        o_action1_out = (r_state == StIssue) ? r_lat1 : ACT_AWAIT;
        o_action2_out = (r_state == StIssue) ? r_lat2 : ACT_AWAIT;
        o_step        = (r_state == StIssue);
        o_round_rst   = (r_state == StRoundInit);
        o_match_over  = (r_state == StMatchEnd);
        o_round_num   = r_round_num;
        o_wins1       = r_wins1;
        o_wins2       = r_wins2;
        o_turn_cnt    = r_turn_cnt;
        o_winner      = r_winner;
    end

endmodule
